// File: rtl/hwpe_stream_deserialize_reg_pkg.sv
// Shared defaults and elaboration helpers for the registered stream deserializer.
// Holds no typedefs; stream signals live in hwpe_stream_intf_stream.
package hwpe_stream_deserialize_reg_pkg;

    localparam int unsigned DEFAULT_NB_IN_BEATS    = 2;
    localparam int unsigned DEFAULT_DATA_WIDTH_OUT = 128;

    // Constant function, usable in elaboration-time parameter checks.
    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/hwpe_stream_deserialize_reg_if.sv
// Generic valid/ready stream bundle with byte strobes.
// The source drives data/strb/valid and the sink drives ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (
        output valid,
        output data,
        output strb,
        input  ready
    );

    modport sink (
        input  valid,
        input  data,
        input  strb,
        output ready
    );

endinterface

// File: rtl/hwpe_stream_deserialize_reg.sv
// Packs NB_IN_BEATS narrow beats into one wide word, lane 0 in the LSBs.
// One-cycle latency, full throughput, and a flush that closes a partial word.
module hwpe_stream_deserialize_reg
    import hwpe_stream_deserialize_reg_pkg::*;
#(
    parameter int unsigned NB_IN_BEATS    = DEFAULT_NB_IN_BEATS,
    parameter int unsigned DATA_WIDTH_OUT = DEFAULT_DATA_WIDTH_OUT
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           flush_i,
    hwpe_stream_intf_stream.sink           push_i,
    hwpe_stream_intf_stream.source         pop_o,
    output logic [$clog2(NB_IN_BEATS)-1:0] beat_cnt_o
);

    localparam int unsigned DATA_WIDTH_IN = DATA_WIDTH_OUT / NB_IN_BEATS;
    localparam int unsigned STRB_WIDTH_IN = DATA_WIDTH_IN / 8;
    localparam int unsigned CNT_WIDTH     = $clog2(NB_IN_BEATS);

    if ((NB_IN_BEATS < 2) || !is_pow2(NB_IN_BEATS) ||
        ((DATA_WIDTH_OUT % (8 * NB_IN_BEATS)) != 0)) begin : gen_param_check
        $error("hwpe_stream_deserialize_reg: illegal NB_IN_BEATS/DATA_WIDTH_OUT");
    end

    logic [CNT_WIDTH-1:0]                           cnt_q, cnt_d;
    logic [NB_IN_BEATS-1:0][DATA_WIDTH_IN-1:0]      data_q, data_d;
    logic [NB_IN_BEATS-1:0][STRB_WIDTH_IN-1:0]      strb_q, strb_d;
    logic                                           full_q, full_d;

    logic push_ready;
    logic accept;
    logic pop_fire;
    logic last_lane;

    assign push_ready = ~full_q | pop_o.ready;
    assign accept     = push_i.valid & push_ready;
    assign pop_fire   = full_q & pop_o.ready;
    assign last_lane  = (cnt_q == CNT_WIDTH'(NB_IN_BEATS - 1));

    assign push_i.ready = push_ready;
    assign pop_o.valid  = full_q;
    assign pop_o.data   = data_q;
    assign pop_o.strb   = strb_q;
    assign beat_cnt_o   = cnt_q;

    // A held word always has cnt=0, so a lane-0 accept is exactly a new word
    // start; wiping the upper strobes there keeps flushed words clean.
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        strb_d = strb_q;
        full_d = full_q;

        if (pop_fire) begin
            full_d = 1'b0;
        end

        if (accept) begin
            if (cnt_q == '0) begin
                for (int i = 1; i < NB_IN_BEATS; i++) begin
                    strb_d[i] = '0;
                end
            end
            data_d[cnt_q] = push_i.data;
            strb_d[cnt_q] = push_i.strb;
            cnt_d         = cnt_q + CNT_WIDTH'(1);
            if (last_lane) begin
                full_d = 1'b1;
            end
        end

        if (flush_i && (cnt_d != '0)) begin
            full_d = 1'b1;
            cnt_d  = '0;
        end

        if (clear_i) begin
            cnt_d  = '0;
            data_d = '0;
            strb_d = '0;
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            data_q <= '0;
            strb_q <= '0;
            full_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
            strb_q <= strb_d;
            full_q <= full_d;
        end
    end

endmodule

// File: tb/tb_hwpe_stream_deserialize_reg.sv
// Self-checking bench for hwpe_stream_deserialize_reg (4 beats x 32 bit -> 128 bit).
// Directed scenarios followed by randomized traffic against a queue-based word model.
module tb_hwpe_stream_deserialize_reg;

    localparam int NB  = 4;
    localparam int DWO = 128;
    localparam int DWI = 32;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] beat_cnt;

    always #5 clk = ~clk;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DWI)) push ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DWO)) pop ();

    hwpe_stream_deserialize_reg #(
        .NB_IN_BEATS   (NB),
        .DATA_WIDTH_OUT(DWO)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clear_i   (clear),
        .flush_i   (flush),
        .push_i    (push),
        .pop_o     (pop),
        .beat_cnt_o(beat_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: beats collected so far, and the word currently offered.
    logic [31:0] part_data[$];
    logic [3:0]  part_strb[$];
    bit          held;
    int          held_n;
    logic [31:0] held_data[NB];
    logic [15:0] held_strb;

    task automatic checkValue(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void modelReset();
        held      = 1'b0;
        held_n    = 0;
        held_strb = '0;
        part_data.delete();
        part_strb.delete();
    endfunction

    function automatic void modelClose();
        held      = 1'b1;
        held_n    = part_data.size();
        held_strb = '0;
        for (int i = 0; i < held_n; i++) begin
            held_data[i]       = part_data[i];
            held_strb[i*4 +: 4] = part_strb[i];
        end
        part_data.delete();
        part_strb.delete();
    endfunction

    function automatic void modelStep(input bit v, input logic [31:0] d, input logic [3:0] s,
                                      input bit pr, input bit fl, input bit cl);
        bit rdy;
        if (cl) begin
            modelReset();
        end else begin
            rdy = !held || pr;
            if (held && pr) held = 1'b0;
            if (v && rdy) begin
                part_data.push_back(d);
                part_strb.push_back(s);
                if (part_data.size() == NB) modelClose();
            end
            if (fl && part_data.size() != 0) modelClose();
        end
    endfunction

    task automatic checkOutput();
        checkValue("pop_valid", pop.valid, held);
        checkValue("push_ready", push.ready, (!held || pop.ready));
        checkValue("beat_cnt", beat_cnt, part_data.size());
        if (held) begin
            checkValue("pop_strb", pop.strb, held_strb);
            for (int i = 0; i < held_n; i++) begin
                checkValue($sformatf("pop_lane%0d", i), pop.data[i*32 +: 32], held_data[i]);
            end
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] d, input logic [3:0] s,
                                 input bit pr, input bit fl, input bit cl);
        @(negedge clk);
        push.valid = v;
        push.data  = d;
        push.strb  = s;
        pop.ready  = pr;
        flush      = fl;
        clear      = cl;
        #1;
        checkOutput();
        modelStep(v, d, s, pr, fl, cl);
    endtask

    task automatic checkResetValues(input string tag);
        checkValue({tag, "_valid"}, pop.valid, 1'b0);
        checkValue({tag, "_data"}, pop.data, '0);
        checkValue({tag, "_strb"}, pop.strb, '0);
        checkValue({tag, "_ready"}, push.ready, 1'b1);
        checkValue({tag, "_cnt"}, beat_cnt, 2'd0);
    endtask

    initial begin
        push.valid = 1'b0;
        push.data  = '0;
        push.strb  = '0;
        pop.ready  = 1'b0;
        modelReset();

        #3;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] back-to-back word");
        for (int i = 0; i < NB; i++) applyStimulus(1, 32'hA0 + i, 4'hF, 1, 0, 0);
        @(posedge clk);
        #1;
        checkValue("s1_data", pop.data, 128'h000000A3_000000A2_000000A1_000000A0);
        checkValue("s1_strb", pop.strb, 16'hFFFF);
        checkValue("s1_valid", pop.valid, 1'b1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);

        $display("[TB] stalled output");
        for (int i = 0; i < NB; i++) applyStimulus(1, 32'hB0 + i, 4'hF, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'hC0, 4'hF, 0, 0, 0);
        checkValue("s2_stall_data", pop.data, 128'h000000B3_000000B2_000000B1_000000B0);
        checkValue("s2_stall_ready", push.ready, 1'b0);
        for (int i = 0; i < NB; i++) applyStimulus(1, 32'hC0 + i, 4'hF, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);

        $display("[TB] flush of a partial word");
        applyStimulus(1, 32'h11, 4'hF, 1, 0, 0);
        applyStimulus(1, 32'h22, 4'hF, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        @(posedge clk);
        #1;
        checkValue("s3_valid", pop.valid, 1'b1);
        checkValue("s3_strb", pop.strb, 16'h00FF);
        checkValue("s3_lanes", pop.data[63:0], 64'h00000022_00000011);
        checkValue("s3_cnt", beat_cnt, 2'd0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);

        $display("[TB] full word then flushed word");
        for (int i = 0; i < NB; i++) applyStimulus(1, 32'hD0 + i, 4'hF, 1, 0, 0);
        applyStimulus(1, 32'hE0, 4'hF, 1, 0, 0);
        applyStimulus(1, 32'hE1, 4'hF, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        @(posedge clk);
        #1;
        checkValue("s4_strb", pop.strb, 16'h00FF);
        applyStimulus(0, 0, 0, 1, 0, 0);

        $display("[TB] clear mid-word");
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h50 + i, 4'hF, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 1);
        @(posedge clk);
        #1;
        checkValue("s5_cnt", beat_cnt, 2'd0);
        checkValue("s5_valid", pop.valid, 1'b0);
        for (int i = 0; i < NB; i++) applyStimulus(1, 32'hF0 + i, 4'h5, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);

        $display("[TB] async reset while holding a word");
        for (int i = 0; i < NB; i++) applyStimulus(1, 32'h70 + i, 4'hF, 0, 0, 0);
        applyStimulus(1, 32'h99, 4'hF, 0, 0, 0);
        @(negedge clk);
        push.valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkResetValues("async_rst");
        modelReset();
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1, 0, 0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 49) == 0);
        end
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
